// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: resolves load-use, EX redirects and
// memory wait states, holds a redirect that arrives during a fetch stall, and counts stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_sel_redir,
  output logic [XLEN-1:0]  redir_pc,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state,
  output logic             dbg_pend_v,
  output logic [XLEN-1:0]  dbg_pend_pc
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_IF_WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic             pend_v_q, pend_v_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu;
  logic             frozen;
  logic             fetch_wait;
  logic             flush_inc;

  assign lu = ex_is_load && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Once in MEM_WAIT the pipe stays frozen until the data memory answers.
  assign frozen = !dmem_ready && (dmem_req || (state_q == ST_MEM_WAIT));

  // A held redirect keeps us in fetch-wait context even across a memory freeze.
  assign fetch_wait = (state_q == ST_IF_WAIT) || pend_v_q;

  always_comb begin
    state_d      = ST_RUN;
    pend_v_d     = pend_v_q;
    pend_pc_d    = pend_pc_q;
    flush_inc    = 1'b0;
    pc_we        = 1'b1;
    pc_sel_redir = 1'b0;
    redir_pc     = '0;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_flush   = 1'b0;
    exmem_we     = 1'b1;

    if (!sys_rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      exmem_we   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pend_v_d   = 1'b0;
      pend_pc_d  = '0;
    end else if (frozen) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = ST_MEM_WAIT;
    end else if (ex_redirect && fetch_wait && !imem_ready) begin
      // Fetch cannot take the new PC yet: remember it and squash the EX successor.
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pend_v_d   = 1'b1;
      pend_pc_d  = ex_target;
      flush_inc  = 1'b1;
      state_d    = ST_IF_WAIT;
    end else if (ex_redirect) begin
      pc_sel_redir = 1'b1;
      redir_pc     = ex_target;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      pend_v_d     = 1'b0;
      flush_inc    = 1'b1;
    end else if (pend_v_q && imem_ready) begin
      pc_sel_redir = 1'b1;
      redir_pc     = pend_pc_q;
      ifid_flush   = 1'b1;
      pend_v_d     = 1'b0;
    end else if (pend_v_q) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
      state_d    = ST_IF_WAIT;
    end else if (lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
      state_d    = ST_IF_WAIT;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RUN;
      pend_v_q    <= 1'b0;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_pend_v  = pend_v_q;
  assign dbg_pend_pc = pend_pc_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow counter width makes saturation reachable.
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  // Control vector order: {pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}
  localparam logic [6:0] C_RUN   = 7'b1010101;
  localparam logic [6:0] C_LU    = 7'b0000111;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_FETCH = 7'b0011101;
  localparam logic [6:0] C_LATCH = 7'b0011111;
  localparam logic [6:0] C_PEND  = 7'b1111101;
  localparam logic [6:0] C_RST   = 7'b0001010;

  localparam logic [1:0] S_RUN = 2'd0, S_MEM = 2'd1, S_IFW = 2'd2;

  logic             sys_clk, sys_rst_n;
  logic [RA_W-1:0]  id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic             imem_ready, dmem_req, dmem_ready;
  logic             pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;
  logic [XLEN-1:0]  redir_pc, dbg_pend_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       dbg_state;
  logic             dbg_pend_v;
  logic [6:0]       ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .pc_sel_redir(pc_sel_redir), .redir_pc(redir_pc),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_we(exmem_we), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state), .dbg_pend_v(dbg_pend_v), .dbg_pend_pc(dbg_pend_pc)
  );

  assign ctrl = {pc_we, pc_sel_redir, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we};

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic drive_lu_rs1(input logic [RA_W-1:0] r);
    ex_is_load = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    drive_idle();
    sys_rst_n = 1'b0;
    #3;
    check_eq("reset_ctrl", 64'(ctrl), 64'(C_RST));
    check_eq("reset_redir_pc", 64'(redir_pc), 64'h0);
    check_eq("reset_counters", 64'({stall_cnt, flush_cnt}), 64'h0);
    check_eq("reset_state", 64'({dbg_state, dbg_pend_v}), 64'h0);
    #4 sys_rst_n = 1'b1;
    tick();

    drive_idle(); settle();
    check_eq("run_idle", 64'(ctrl), 64'(C_RUN));
    tick();

    // Load-use on rs1: one bubble, then free again
    drive_lu_rs1(5'd5); settle();
    check_eq("lu_rs1_ctrl", 64'(ctrl), 64'(C_LU));
    tick();
    drive_idle(); settle();
    check_eq("lu_after_ctrl", 64'(ctrl), 64'(C_RUN));
    check_eq("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    tick();

    // Load-use via rs2 only
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    id_rs1 = 5'd7; id_use_rs1 = 1'b0; settle();
    check_eq("lu_rs2_ctrl", 64'(ctrl), 64'(C_LU));
    tick();
    // Matching rs1 that is not read: no hazard
    drive_idle(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0; settle();
    check_eq("lu_unused_ctrl", 64'(ctrl), 64'(C_RUN));
    tick();
    // x0 destination never stalls
    drive_idle(); drive_lu_rs1(5'd0); settle();
    check_eq("lu_x0_ctrl", 64'(ctrl), 64'(C_RUN));
    tick();
    check_eq("lu_x0_stall_cnt", 64'(stall_cnt), 64'd2);

    // Redirect overrides load-use
    drive_idle(); drive_lu_rs1(5'd3); ex_redirect = 1'b1; ex_target = 32'h0000_0100; settle();
    check_eq("redir_ctrl", 64'(ctrl), 64'(C_REDIR));
    check_eq("redir_pc", 64'(redir_pc), 64'h100);
    tick();
    drive_idle(); settle();
    check_eq("redir_flush_cnt", 64'(flush_cnt), 64'd1);
    check_eq("redir_stall_cnt", 64'(stall_cnt), 64'd2);

    // Memory freeze masks a redirect for 3 cycles
    ex_redirect = 1'b1; ex_target = 32'h0000_0180; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("frz_ctrl", 64'(ctrl), 64'(C_FRZ));
      tick();
      check_eq("frz_state", 64'(dbg_state), 64'(S_MEM));
    end
    dmem_ready = 1'b1; settle();
    check_eq("frz_exit_ctrl", 64'(ctrl), 64'(C_REDIR));
    check_eq("frz_exit_pc", 64'(redir_pc), 64'h180);
    tick();
    check_eq("frz_stall_cnt", 64'(stall_cnt), 64'd5);
    check_eq("frz_flush_cnt", 64'(flush_cnt), 64'd2);
    check_eq("frz_state_run", 64'(dbg_state), 64'(S_RUN));

    // Fetch stall with two redirects landing in the pending slot
    drive_idle(); imem_ready = 1'b0; settle();
    check_eq("if_stall_ctrl", 64'(ctrl), 64'(C_FETCH));
    tick();
    check_eq("if_state", 64'(dbg_state), 64'(S_IFW));
    ex_redirect = 1'b1; ex_target = 32'h200; settle();
    check_eq("if_latch_ctrl", 64'(ctrl), 64'(C_LATCH));
    tick();
    check_eq("if_pend_200", 64'({dbg_pend_v, dbg_pend_pc}), {31'd0, 1'b1, 32'h200});
    ex_target = 32'h300; tick();
    check_eq("if_pend_300", 64'({dbg_pend_v, dbg_pend_pc}), {31'd0, 1'b1, 32'h300});
    ex_redirect = 1'b0; settle();
    check_eq("if_hold_ctrl", 64'(ctrl), 64'(C_FETCH));
    tick();
    imem_ready = 1'b1; settle();
    check_eq("if_apply_ctrl", 64'(ctrl), 64'(C_PEND));
    check_eq("if_apply_pc", 64'(redir_pc), 64'h300);
    tick();
    check_eq("if_done_state", 64'({dbg_state, dbg_pend_v}), 64'h0);
    check_eq("if_flush_cnt", 64'(flush_cnt), 64'd4);
    check_eq("if_stall_cnt", 64'(stall_cnt), 64'd9);

    // Redirect coinciding with fetch return wins over the held target
    imem_ready = 1'b0; tick();
    ex_redirect = 1'b1; ex_target = 32'h400; tick();
    ex_target = 32'h500; imem_ready = 1'b1; settle();
    check_eq("if_direct_ctrl", 64'(ctrl), 64'(C_REDIR));
    check_eq("if_direct_pc", 64'(redir_pc), 64'h500);
    tick();
    check_eq("if_direct_pend", 64'({dbg_state, dbg_pend_v}), 64'h0);
    check_eq("if_direct_flush", 64'(flush_cnt), 64'd6);
    check_eq("if_direct_stall", 64'(stall_cnt), 64'd11);

    // Saturation of both counters
    drive_idle(); drive_lu_rs1(5'd4);
    for (int i = 0; i < 8; i++) tick();
    check_eq("stall_sat", 64'(stall_cnt), 64'd15);
    drive_idle(); ex_redirect = 1'b1; ex_target = 32'h600;
    for (int i = 0; i < 12; i++) tick();
    check_eq("flush_sat", 64'(flush_cnt), 64'd15);

    // Reset while a redirect is pending in IF_WAIT
    drive_idle(); imem_ready = 1'b0; tick();
    ex_redirect = 1'b1; ex_target = 32'h700; tick();
    check_eq("pre_rst_pend", 64'({dbg_state, dbg_pend_v}), 64'({S_IFW, 1'b1}));
    #2 sys_rst_n = 1'b0; settle();
    check_eq("rst_mid_ctrl", 64'(ctrl), 64'(C_RST));
    check_eq("rst_mid_redir", 64'(redir_pc), 64'h0);
    check_eq("rst_mid_state", 64'({dbg_state, dbg_pend_v, dbg_pend_pc}), 64'h0);
    check_eq("rst_mid_cnt", 64'({stall_cnt, flush_cnt}), 64'h0);
    tick();
    check_eq("rst_hold_ctrl", 64'(ctrl), 64'(C_RST));
    #2 sys_rst_n = 1'b1;
    drive_idle(); tick(); settle();
    check_eq("post_rst_ctrl", 64'(ctrl), 64'(C_RUN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It drives the write-enables and bubble-inserts of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, EX-stage redirects (taken branch/jump) and instruction/data memory wait states. It also holds a pending redirect target while fetch is stalled, and keeps stall/flush performance counters.

Parameters:
XLEN, 32, datapath/PC width (matches `width)
RA_W, 5, register address width
CNT_W, 16, performance counter width

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  async active-low reset
id_rs1  in  RA_W  ID-stage source reg 1
id_rs2  in  RA_W  ID-stage source reg 2
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_rd  in  RA_W  EX-stage dest reg
ex_is_load  in  1  EX instr is a load
ex_redirect  in  1  EX resolved taken branch/jump
ex_target  in  XLEN  redirect target
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage has a memory access
dmem_ready  in  1  data memory completes this cycle
pc_we  out  1  PC register update enable
pc_sel_redir  out  1  PC next = redir_pc (else pc+4)
redir_pc  out  XLEN  redirect target to PC mux
ifid_we  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads NOP
idex_we  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads NOP
exmem_we  out  1  EX/MEM and MEM/WB enable
stall_cnt  out  CNT_W  cycles with pc_we=0
flush_cnt  out  CNT_W  redirects applied

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- State registers: state ∈ {RUN, MEM_WAIT, IF_WAIT}, pend_v, pend_pc, stall_cnt, flush_cnt.
- Reset values: state=RUN, pend_v=0, pend_pc=0, counters=0.
- While sys_rst_n=0: all *_we=0, ifid_flush=idex_flush=1, pc_sel_redir=0, redir_pc=0.
- Control outputs are combinational from state and inputs. Only state, pending and counter registers are clocked. Zero-cycle decision latency.
- Default in RUN: all *_we=1, flushes=0, pc_sel_redir=0.
- Load-use condition: lu = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority each cycle: mem stall > redirect > load-use > fetch stall.
- Mem stall (dmem_req & !dmem_ready, any state):
  - All *_we=0, no flushes.
  - Next state=MEM_WAIT.
  - Leave MEM_WAIT on the first cycle with dmem_ready=1. That cycle behaves as RUN.
  - ex_redirect is ignored while frozen; the EX instr holds, so it re-presents.
- Redirect (ex_redirect, not frozen):
  - pc_we=1, pc_sel_redir=1, redir_pc=ex_target.
  - ifid_flush=1, idex_flush=1. Overrides lu.
  - flush_cnt++.
- Load-use only:
  - pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1.
  - One bubble; resolves next cycle because the load moves to MEM.
- Fetch stall (!imem_ready, no higher event):
  - pc_we=0, ifid_flush=1; downstream advances.
  - state=IF_WAIT.
- IF_WAIT:
  - A redirect arriving while imem_ready=0 latches pend_v=1, pend_pc=ex_target and flushes ID/EX. flush_cnt++ at latch time.
  - A later redirect overwrites pend_pc.
  - When imem_ready=1 and pend_v=1: pc_we=1, pc_sel_redir=1, redir_pc=pend_pc, ifid_flush=1 (wrong-path fetch discarded), pend_v←0, state←RUN.
  - When imem_ready=1 and pend_v=0: RUN behaviour.
  - A redirect in the same cycle as imem_ready=1 uses ex_target directly and clears pend_v.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_we=0.
  - Both counters saturate at all-ones; no wrap.
- Reset asserted mid-stall: immediate return to reset values; pending redirect is discarded.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle all we=1; stall_cnt=1.
- ex_rd=0 with matching rs1=0 and ex_is_load=1 -> no stall, all we=1.
- ex_redirect=1, ex_target=0x0000_0100, with lu also true -> pc_sel_redir=1, redir_pc=0x100, ifid_flush=idex_flush=1, pc_we=1; flush_cnt=1.
- dmem_req=1, dmem_ready=0 for 3 cycles while ex_redirect=1 -> all we=0 for 3 cycles, no redirect applied. Cycle 4 (dmem_ready=1): redirect applied, stall_cnt=3.
- imem_ready=0 for 4 cycles; redirect 0x200 in cycle 2, then 0x300 in cycle 3 -> pend_pc=0x300. On imem_ready=1: redir_pc=0x300, ifid_flush=1, pend_v=0; flush_cnt=2.
- Reset pulse during IF_WAIT with pend_v=1 -> pend_v=0, state RUN, counters 0, enables low while reset is asserted.
